// File: rtl/sll_arb_64b.sv
// Round-robin arbiter sharing one 64-bit left shifter between requesters.
// Sequences init/done with the shifter; a watchdog returns an error on timeout.
module sll_arb_64b #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  output logic [N_REQ-1:0]    req_ready_o,
  input  logic [6*N_REQ-1:0]  req_shift_i,
  input  logic [64*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]    rsp_valid_o,
  input  logic [N_REQ-1:0]    rsp_ready_i,
  output logic [63:0]         rsp_data_o,
  output logic                rsp_err_o,
  output logic                sh_init_o,
  output logic [5:0]          sh_shift_o,
  output logic [63:0]         sh_data_o,
  input  logic                sh_done_i,
  input  logic [63:0]         sh_data_i
);

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_q, gnt_d;
  logic [5:0]  shift_q, shift_d;
  logic [63:0] data_q, data_d;
  logic [63:0] res_q, res_d;
  logic        err_q, err_d;
  logic [7:0]  wd_q, wd_d;

  logic             found;
  logic [PW-1:0]    pick;
  logic [N_REQ-1:0] pick_oh;
  logic [5:0]       pick_shift;
  logic [63:0]      pick_data;
  int               idx;

  // search starts just after the last served requester
  always_comb begin
    found      = 1'b0;
    pick       = '0;
    pick_oh    = '0;
    pick_shift = '0;
    pick_data  = '0;
    idx        = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid_i[idx]) begin
        found        = 1'b1;
        pick         = PW'(idx);
        pick_oh[idx] = 1'b1;
        pick_shift   = req_shift_i[6*idx +: 6];
        pick_data    = req_data_i[64*idx +: 64];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    res_d       = res_q;
    err_d       = err_q;
    wd_d        = wd_q;
    req_ready_o = '0;
    sh_init_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready_o = pick_oh;
          gnt_d       = pick;
          shift_d     = pick_shift;
          data_d      = pick_data;
          wd_d        = 8'd0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        sh_init_o = 1'b1;
        if (sh_done_i) begin
          res_d   = sh_data_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_q == 8'(TIMEOUT)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i[gnt_q]) begin
          ptr_d   = gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rsp_valid_o[k] = (state_q == RESP) && (gnt_q == PW'(k));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= PW'(N_REQ - 1);
      gnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      res_q   <= res_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  assign sh_shift_o = shift_q;
  assign sh_data_o  = data_q;
  assign rsp_data_o = res_q;
  assign rsp_err_o  = err_q;

endmodule

// File: tb/tb_sll_arb_64b.sv
// Directed bench for sll_arb_64b with a behavioural shifter.
// Shifter mode: 0 = combinational done, 1 = registered done, 2 = never done.
module tb_sll_arb_64b;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready;
  logic [N-1:0]    rsp_valid, rsp_ready;
  logic [6*N-1:0]  req_shift;
  logic [64*N-1:0] req_data;
  logic [63:0]     rsp_data;
  logic            rsp_err;
  logic            sh_init, sh_done;
  logic [5:0]      sh_shift;
  logic [63:0]     sh_dout, sh_din;

  int          mode = 1;
  logic        done_r = 1'b0;
  logic [63:0] data_r = '0;

  always @(posedge clk) begin
    done_r <= sh_init;
    data_r <= sh_dout << sh_shift;
  end

  assign sh_done = (mode == 0) ? sh_init :
                   (mode == 1) ? done_r : 1'b0;
  assign sh_din  = (mode == 0) ? (sh_dout << sh_shift) : data_r;

  sll_arb_64b #(.N_REQ(N), .TIMEOUT(15)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_shift_i (req_shift),
    .req_data_i  (req_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .sh_init_o   (sh_init),
    .sh_shift_o  (sh_shift),
    .sh_data_o   (sh_dout),
    .sh_done_i   (sh_done),
    .sh_data_i   (sh_din)
  );

  int n_vec = 0;
  int n_err = 0;

  int rr_ord [6] = '{0, 1, 2, 3, 0, 1};
  logic [63:0] rr_exp [4] = '{
    64'h2,
    64'h2345_6789_ABCD_EF00,
    64'hC000_0000_0000_0000,
    64'hDEAD_BEEF_0000_0000
  };

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int k,
                    input logic [5:0] sh,
                    input logic [63:0] d,
                    input int lat,
                    input logic [63:0] exp,
                    input string tag);
    logic [N-1:0] oh;
    oh = '0;
    oh[k] = 1'b1;
    req_shift[6*k +: 6] = sh;
    req_data[64*k +: 64] = d;
    req_valid[k] = 1'b1;
    #1;
    chk({tag, ".ready"}, 64'(req_ready), 64'(oh));
    step();
    req_valid[k] = 1'b0;
    chk({tag, ".init"}, 64'(sh_init), 64'd1);
    repeat (lat - 1) step();
    chk({tag, ".valid"}, 64'(rsp_valid), 64'(oh));
    chk({tag, ".data"}, rsp_data, exp);
    chk({tag, ".err"}, 64'(rsp_err), 64'd0);
    rsp_ready[k] = 1'b1;
    step();
    rsp_ready[k] = 1'b0;
    chk({tag, ".drop"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int c;
    logic [N-1:0] oh;
    req_valid = '0;
    rsp_ready = '0;
    req_shift = '0;
    req_data  = '0;
    mode      = 1;

    // reset values
    rst_n = 1'b0;
    step();
    step();
    chk("rst.ready", 64'(req_ready), 64'd0);
    chk("rst.valid", 64'(rsp_valid), 64'd0);
    chk("rst.data", rsp_data, 64'd0);
    chk("rst.err", 64'(rsp_err), 64'd0);
    chk("rst.init", 64'(sh_init), 64'd0);
    chk("rst.shift", 64'(sh_shift), 64'd0);
    chk("rst.sdata", sh_dout, 64'd0);
    rst_n = 1'b1;

    // single op, registered shifter
    op(0, 6'd4, 64'hFFFF_FFFF_FFFF_FFFF, 3,
       64'hFFFF_FFFF_FFFF_FFF0, "single");
    for (int s = 0; s < 64; s++) begin
      op(0, 6'(s), 64'd1, 3, 64'd1 << s, "walk");
    end

    // round robin from a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_shift = {6'd32, 6'd62, 6'd8, 6'd1};
    req_data  = {64'hDEAD_BEEF, 64'h3,
                 64'h0123_4567_89AB_CDEF, 64'h1};
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    #1;
    for (int n = 0; n < 6; n++) begin
      oh = 4'b0001 << rr_ord[n];
      c = 0;
      while (req_ready == '0 && c < 20) begin
        step();
        c++;
      end
      chk("rr.grant", 64'(req_ready), 64'(oh));
      step();
      c = 0;
      while (rsp_valid == '0 && c < 20) begin
        step();
        c++;
      end
      chk("rr.valid", 64'(rsp_valid), 64'(oh));
      chk("rr.data", rsp_data, rr_exp[rr_ord[n]]);
      step();
    end
    req_valid = '0;
    rsp_ready = '0;
    step();

    // response backpressure
    req_shift[6 +: 6]  = 6'd3;
    req_data[64 +: 64] = 64'h5;
    req_valid = 4'b0010;
    #1;
    chk("bp.grant", 64'(req_ready), 64'h2);
    step();
    req_valid = 4'b1000;
    req_shift[18 +: 6]  = 6'd0;
    req_data[192 +: 64] = 64'h1;
    rsp_ready = 4'b1101;
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      chk("bp.valid", 64'(rsp_valid), 64'h2);
      chk("bp.data", rsp_data, 64'h28);
      chk("bp.ready", 64'(req_ready), 64'd0);
      chk("bp.init", 64'(sh_init), 64'd0);
      step();
    end
    rsp_ready = 4'b0010;
    step();
    rsp_ready = '0;
    chk("bp.next", 64'(req_ready), 64'h8);
    step();
    req_valid = '0;
    step();
    step();
    chk("bp.v3", 64'(rsp_valid), 64'h8);
    chk("bp.d3", rsp_data, 64'h1);
    rsp_ready = 4'b1000;
    step();
    rsp_ready = '0;

    // watchdog timeout with a dead shifter
    mode = 2;
    req_shift[12 +: 6]  = 6'd1;
    req_data[128 +: 64] = 64'hAB;
    req_valid = 4'b0100;
    #1;
    chk("tmo.grant", 64'(req_ready), 64'h4);
    step();
    req_valid = '0;
    repeat (15) step();
    chk("tmo.early", 64'(rsp_valid), 64'd0);
    chk("tmo.init", 64'(sh_init), 64'd1);
    step();
    chk("tmo.valid", 64'(rsp_valid), 64'h4);
    chk("tmo.err", 64'(rsp_err), 64'd1);
    chk("tmo.data", rsp_data, 64'd0);
    rsp_ready = 4'b0100;
    step();
    rsp_ready = '0;
    mode = 1;
    op(2, 6'd1, 64'hAB, 3, 64'h156, "tmo.next");

    // reset while busy
    req_shift[0 +: 6]  = 6'd8;
    req_data[0 +: 64]  = 64'hFF;
    req_valid = 4'b0001;
    #1;
    step();
    req_valid = '0;
    chk("mrst.busy", 64'(sh_init), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst.init", 64'(sh_init), 64'd0);
    chk("mrst.shift", 64'(sh_shift), 64'd0);
    chk("mrst.sdata", sh_dout, 64'd0);
    chk("mrst.valid", 64'(rsp_valid), 64'd0);
    chk("mrst.data", rsp_data, 64'd0);
    chk("mrst.err", 64'(rsp_err), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mrst.norsp", 64'(rsp_valid), 64'd0);
    end
    req_shift[0 +: 6] = 6'd4;
    req_data[0 +: 64] = 64'h7;
    req_valid = 4'hF;
    #1;
    chk("mrst.grant", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    step();
    step();
    chk("mrst.rv", 64'(rsp_valid), 64'h1);
    chk("mrst.rd", rsp_data, 64'h70);
    rsp_ready = 4'b0001;
    step();
    rsp_ready = '0;

    // combinational shifter
    mode = 0;
    op(2, 6'd63, 64'd1, 2, 64'h8000_0000_0000_0000, "or0");
    req_shift[12 +: 6]  = 6'd4;
    req_data[128 +: 64] = 64'h3;
    req_valid = 4'b0100;
    rsp_ready = 4'b0100;
    #1;
    for (int n = 0; n < 3; n++) begin
      chk("b2b.grant", 64'(req_ready), 64'h4);
      step();
      chk("b2b.gap", 64'(req_ready), 64'd0);
      chk("b2b.init", 64'(sh_init), 64'd1);
      step();
      chk("b2b.valid", 64'(rsp_valid), 64'h4);
      chk("b2b.data", rsp_data, 64'h30);
      step();
    end
    req_valid = '0;
    rsp_ready = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
